// File: rtl/toe_pkg.sv
// Shared TOE definitions: connection-record word map, protocol constants, FSM states, record layout.
package toe_pkg;

    localparam logic [3:0] W_CTRL       = 4'd0;
    localparam logic [3:0] W_MAC_DST_LO = 4'd1;
    localparam logic [3:0] W_MAC_SRC_HI = 4'd2;
    localparam logic [3:0] W_MAC_SRC_LO = 4'd3;
    localparam logic [3:0] W_IP_SRC     = 4'd4;
    localparam logic [3:0] W_IP_DST     = 4'd5;
    localparam logic [3:0] W_PORTS      = 4'd6;
    localparam logic [3:0] W_SEQ        = 4'd7;
    localparam logic [3:0] W_ACK        = 4'd8;
    localparam int         REC_WORDS    = 9;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'h06;
    localparam int          HDR_BYTES     = 54;
    localparam int          HDR_BITS      = HDR_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_CSUM,
        ST_EMIT,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [31:0] ports;
        logic [31:0] seq;
        logic [31:0] ack;
    } conn_rec_t;

    // One's-complement 16-bit add with end-around carry.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/ip_checksum.sv
// IPv4 header checksum accumulator: one 16-bit word per acc_en cycle, result is the inverted sum.
// Latency: result reflects all words accumulated up to the previous clock edge.
// Backpressure: none; the caller sequences clear/acc_en.
module ip_checksum
    import toe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        acc_en,
    input  logic [15:0] word,
    output logic [15:0] result
);

    logic [15:0] acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= csum_add(acc, word);
        end
    end

    assign result = ~acc;

endmodule

// File: rtl/tcp_hdr_streamer.sv
// Fetches a connection record and streams the 54-byte Eth/IPv4/TCP header as OUT_W-bit beats (TOE_IP_CSUM_EN adds IP checksum).
// Latency: request accept to first beat is 9+RAM_LAT+2 cycles, +10 with TOE_IP_CSUM_EN.
// Backpressure: beats hold while hdr_valid && !hdr_ready; req_ready only in IDLE.
module tcp_hdr_streamer
    import toe_pkg::*;
#(
    parameter int          ID_W    = 6,
    parameter int          OUT_W   = 32,
    parameter int          RAM_LAT = 2,
    parameter logic [7:0]  TTL     = 8'd64,
    parameter logic [15:0] WINDOW  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ID_W-1:0]    req_id,
    input  logic [7:0]         req_flags,
    input  logic [15:0]        req_len,
    output logic [ID_W+3:0]    ram_addr,
    input  logic [31:0]        ram_rdata,
    output logic               hdr_valid,
    input  logic               hdr_ready,
    output logic [OUT_W-1:0]   hdr_data,
    output logic [OUT_W/8-1:0] hdr_keep,
    output logic               hdr_last,
    output logic               err_pulse,
    output logic               busy
);

    localparam int BPB        = OUT_W / 8;
    localparam int NBEATS     = (HDR_BYTES + BPB - 1) / BPB;
    localparam int PAD_W      = NBEATS * OUT_W;
    localparam int LAST_BYTES = HDR_BYTES - (NBEATS - 1) * BPB;
    localparam logic [BPB-1:0] KEEP_ALL   = '1;
    localparam logic [BPB-1:0] LAST_KEEP  = ~(KEEP_ALL >> LAST_BYTES);
    localparam logic [3:0]     LAST_BEAT  = 4'(NBEATS - 1);
    localparam logic [3:0]     FETCH_LAST = 4'(REC_WORDS + RAM_LAT - 1);
    localparam logic [3:0]     LAT4       = 4'(RAM_LAT);
    localparam logic [15:0]    MAX_LEN    = 16'd65495;

    if (OUT_W != 32 && OUT_W != 64) begin : g_bad_out_w
        $error("tcp_hdr_streamer: OUT_W must be 32 or 64");
    end
    if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_ram_lat
        $error("tcp_hdr_streamer: RAM_LAT must be 1..3");
    end

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        flags_q;
    logic [15:0]       len_q;
    logic [15:0]       ip_id_q;
    conn_rec_t         rec_q;
    logic              rec_vld_q;
    logic [3:0]        widx;
    logic [15:0]       total_len;
    logic [15:0]       ip_csum;
    logic [HDR_BITS-1:0] hdr_vec;
    logic [PAD_W-1:0]  beat_vec;
    logic [PAD_W-1:0]  beat_shift;

    assign widx      = cnt - LAT4;
    assign total_len = 16'd40 + len_q;

`ifdef TOE_IP_CSUM_EN
    localparam logic [3:0] CSUM_LAST = 4'd9;
    logic [15:0] csum_word;

    always_comb begin
        csum_word = '0;
        case (cnt)
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = total_len;
            4'd2:    csum_word = ip_id_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {TTL, IP_PROTO_TCP};
            4'd6:    csum_word = rec_q.ip_src[31:16];
            4'd7:    csum_word = rec_q.ip_src[15:0];
            4'd8:    csum_word = rec_q.ip_dst[31:16];
            4'd9:    csum_word = rec_q.ip_dst[15:0];
            default: csum_word = '0;
        endcase
    end

    ip_checksum u_ip_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_CHECK),
        .acc_en (state == ST_CSUM),
        .word   (csum_word),
        .result (ip_csum)
    );
`else
    // Checksum is left for the MAC to fill in.
    assign ip_csum = 16'h0000;
`endif

    assign hdr_vec = {rec_q.mac_dst, rec_q.mac_src, ETH_TYPE_IPV4,
                      8'h45, 8'h00, total_len, ip_id_q, 16'h4000, TTL, IP_PROTO_TCP, ip_csum,
                      rec_q.ip_src, rec_q.ip_dst,
                      rec_q.ports, rec_q.seq, rec_q.ack, 8'h50, flags_q, WINDOW, 16'h0000, 16'h0000};
    assign beat_vec   = {hdr_vec, {(PAD_W - HDR_BITS){1'b0}}};
    assign beat_shift = beat_vec << (int'(cnt) * OUT_W);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = ST_FETCH;
            ST_FETCH: if (cnt == FETCH_LAST) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!rec_vld_q || len_q > MAX_LEN) begin
                    state_nxt = ST_ERR;
                end else begin
`ifdef TOE_IP_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_EMIT;
`endif
                end
            end
`ifdef TOE_IP_CSUM_EN
            ST_CSUM:  if (cnt == CSUM_LAST) state_nxt = ST_EMIT;
`endif
            ST_EMIT:  if (hdr_ready && cnt == LAST_BEAT) state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        err_pulse = (state == ST_ERR);
        hdr_valid = 1'b0;
        hdr_last  = 1'b0;
        hdr_keep  = '0;
        hdr_data  = '0;
        ram_addr  = '0;
        if (state == ST_FETCH && cnt < 4'(REC_WORDS)) begin
            ram_addr = {id_q, cnt};
        end
        if (state == ST_EMIT) begin
            hdr_valid = 1'b1;
            hdr_last  = (cnt == LAST_BEAT);
            hdr_keep  = (cnt == LAST_BEAT) ? LAST_KEEP : KEEP_ALL;
            hdr_data  = beat_shift[PAD_W-1 -: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            id_q      <= '0;
            flags_q   <= '0;
            len_q     <= '0;
            ip_id_q   <= '0;
            rec_q     <= '0;
            rec_vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // cnt restarts in every state; in EMIT it is the beat index and moves only on acceptance.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != ST_IDLE && (state != ST_EMIT || hdr_ready)) begin
                cnt <= cnt + 4'd1;
            end
            if (state == ST_IDLE && req_valid) begin
                id_q    <= req_id;
                flags_q <= req_flags;
                len_q   <= req_len;
            end
            if (state == ST_FETCH && cnt >= LAT4) begin
                case (widx)
                    W_CTRL: begin
                        rec_vld_q             <= ram_rdata[31];
                        rec_q.mac_dst[47:32]  <= ram_rdata[15:0];
                    end
                    W_MAC_DST_LO: rec_q.mac_dst[31:0]  <= ram_rdata;
                    W_MAC_SRC_HI: rec_q.mac_src[47:32] <= ram_rdata[15:0];
                    W_MAC_SRC_LO: rec_q.mac_src[31:0]  <= ram_rdata;
                    W_IP_SRC:     rec_q.ip_src         <= ram_rdata;
                    W_IP_DST:     rec_q.ip_dst         <= ram_rdata;
                    W_PORTS:      rec_q.ports          <= ram_rdata;
                    W_SEQ:        rec_q.seq            <= ram_rdata;
                    W_ACK:        rec_q.ack            <= ram_rdata;
                    default: ;
                endcase
            end
            if (state == ST_EMIT && hdr_ready && cnt == LAST_BEAT) begin
                ip_id_q <= ip_id_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tcp_hdr_streamer.sv
// Self-checking bench for tcp_hdr_streamer: table vectors, reset-abort sequence, randomized records vs byte-level model.
module tb_tcp_hdr_streamer;

    localparam int ID_W    = 6;
    localparam int OUT_W   = 32;
    localparam int RAM_LAT = 2;
    localparam int BPB     = OUT_W / 8;
    localparam int NBEATS  = (54 + BPB - 1) / BPB;
`ifdef TOE_IP_CSUM_EN
    localparam int EXP_LAT = 9 + RAM_LAT + 2 + 10;
`else
    localparam int EXP_LAT = 9 + RAM_LAT + 2;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [ID_W-1:0]    req_id = '0;
    logic [7:0]         req_flags = '0;
    logic [15:0]        req_len = '0;
    logic [ID_W+3:0]    ram_addr;
    logic [31:0]        ram_rdata;
    logic               hdr_valid;
    logic               hdr_ready = 1'b0;
    logic [OUT_W-1:0]   hdr_data;
    logic [BPB-1:0]     hdr_keep;
    logic               hdr_last;
    logic               err_pulse;
    logic               busy;

    always #5 clk = ~clk;

    tcp_hdr_streamer #(.ID_W(ID_W), .OUT_W(OUT_W), .RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_flags(req_flags), .req_len(req_len),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data),
        .hdr_keep(hdr_keep), .hdr_last(hdr_last),
        .err_pulse(err_pulse), .busy(busy)
    );

    // Connection RAM with RAM_LAT-cycle read pipeline.
    logic [31:0] mem  [0:(1<<(ID_W+4))-1];
    logic [31:0] pipe [0:RAM_LAT-1];
    always @(posedge clk) begin
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[RAM_LAT-1];

    typedef struct {
        logic        valid;
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] ack;
    } rec_t;

    typedef struct {
        int          id;
        logic [7:0]  flags;
        logic [15:0] len;
        bit          rnd;
        bit          exp_err;
        int          exp_beats;
        logic [15:0] exp_total;
    } vec_t;

    rec_t        recs [0:63];
    logic [7:0]  exp_b [0:53];
    logic [15:0] ip_id_model = 16'h0000;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic load_rec(input int id, input rec_t r);
        int b;
        b = id * 16;
        recs[id]  = r;
        mem[b+0]  = {r.valid, 15'b0, r.mac_dst[47:32]};
        mem[b+1]  = r.mac_dst[31:0];
        mem[b+2]  = {16'b0, r.mac_src[47:32]};
        mem[b+3]  = r.mac_src[31:0];
        mem[b+4]  = r.ip_src;
        mem[b+5]  = r.ip_dst;
        mem[b+6]  = {r.sport, r.dport};
        mem[b+7]  = r.seq;
        mem[b+8]  = r.ack;
    endtask

    // Reference header as a byte array in wire order.
    task automatic build_expected(input rec_t r, input logic [7:0] flags, input logic [15:0] len,
                                  input logic [15:0] ipid);
        logic [15:0] tl;
        tl = 16'd40 + len;
        for (int i = 0; i < 6; i++) begin
            exp_b[i]   = r.mac_dst[47-8*i -: 8];
            exp_b[6+i] = r.mac_src[47-8*i -: 8];
        end
        exp_b[12] = 8'h08; exp_b[13] = 8'h00; exp_b[14] = 8'h45; exp_b[15] = 8'h00;
        exp_b[16] = tl[15:8]; exp_b[17] = tl[7:0];
        exp_b[18] = ipid[15:8]; exp_b[19] = ipid[7:0];
        exp_b[20] = 8'h40; exp_b[21] = 8'h00; exp_b[22] = 8'd64; exp_b[23] = 8'h06;
        exp_b[24] = 8'h00; exp_b[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_b[26+i] = r.ip_src[31-8*i -: 8];
            exp_b[30+i] = r.ip_dst[31-8*i -: 8];
            exp_b[38+i] = r.seq[31-8*i -: 8];
            exp_b[42+i] = r.ack[31-8*i -: 8];
        end
        exp_b[34] = r.sport[15:8]; exp_b[35] = r.sport[7:0];
        exp_b[36] = r.dport[15:8]; exp_b[37] = r.dport[7:0];
        exp_b[46] = 8'h50; exp_b[47] = flags; exp_b[48] = 8'hFF; exp_b[49] = 8'hFF;
        for (int i = 50; i < 54; i++) exp_b[i] = 8'h00;
`ifdef TOE_IP_CSUM_EN
        begin
            logic [31:0] sum;
            logic [15:0] cs;
            sum = 0;
            for (int i = 14; i < 34; i += 2) sum += {16'h0, exp_b[i], exp_b[i+1]};
            while (sum[31:16] != 0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
            cs = ~sum[15:0];
            exp_b[24] = cs[15:8]; exp_b[25] = cs[7:0];
        end
`endif
    endtask

    task automatic run_txn(input int id, input logic [7:0] flags, input logic [15:0] len, input bit rnd,
                           input bit exp_err, input int exp_beats, input logic [15:0] exp_total);
        logic [7:0]       got [0:63];
        logic [OUT_W-1:0] pdata, edata;
        logic [BPB-1:0]   pkeep, ekeep;
        logic             plast;
        bit               pstall, done;
        int               nb, n_err, n_beats, cyc, lat, unstable, w, quiet;
        nb = 0; n_err = 0; n_beats = 0; cyc = 0; lat = -1; unstable = 0; pstall = 0; done = 0;
        pdata = '0; pkeep = '0; plast = 1'b0;
        build_expected(recs[id], flags, len, ip_id_model);
        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("req_ready before request", req_ready, 1);
        req_valid = 1'b1; req_id = id[ID_W-1:0]; req_flags = flags; req_len = len;
        while (!done && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            req_valid = 1'b0;
            hdr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (err_pulse) n_err++;
            if (pstall && (!hdr_valid || hdr_data !== pdata || hdr_keep !== pkeep || hdr_last !== plast))
                unstable++;
            if (hdr_valid) begin
                if (lat < 0) lat = cyc;
                if (hdr_ready) begin
                    edata = '0; ekeep = '0;
                    for (int j = 0; j < BPB; j++) begin
                        if (n_beats*BPB + j < 54) begin
                            edata[OUT_W-1-8*j -: 8] = exp_b[n_beats*BPB + j];
                            ekeep[BPB-1-j] = 1'b1;
                        end
                        if (hdr_keep[BPB-1-j] && nb < 64) begin
                            got[nb] = hdr_data[OUT_W-1-8*j -: 8];
                            nb++;
                        end
                    end
                    if (n_beats < NBEATS) begin
                        check($sformatf("beat %0d data id %0d", n_beats, id), hdr_data, edata);
                        check($sformatf("beat %0d keep id %0d", n_beats, id), hdr_keep, ekeep);
                        check($sformatf("beat %0d last id %0d", n_beats, id), hdr_last, n_beats == NBEATS-1);
                    end
                    n_beats++;
                    if (hdr_last || n_beats > NBEATS) done = 1;
                end
            end
            pstall = hdr_valid && !hdr_ready;
            pdata = hdr_data; pkeep = hdr_keep; plast = hdr_last;
            if (n_err > 0 && !busy) done = 1;
        end
        check($sformatf("txn completes within budget id %0d", id), done, 1);
        hdr_ready = 1'b1;
        quiet = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (err_pulse || hdr_valid) quiet++;
        end
        check("no activity after txn", quiet, 0);
        check("req_ready after txn", req_ready, 1);
        check($sformatf("err_pulse count id %0d", id), n_err, exp_err ? 1 : 0);
        check($sformatf("beat count id %0d", id), n_beats, exp_beats);
        check("stable while stalled", unstable, 0);
        if (exp_err) begin
            check("no hdr_valid on error", lat >= 0, 0);
        end else begin
            check("req to first beat latency", lat, EXP_LAT);
            check("total_len field", nb > 17 ? {got[16], got[17]} : 16'h0, exp_total);
`ifdef TOE_IP_CSUM_EN
            begin
                logic [31:0] s;
                s = 0;
                for (int i = 14; i < 34; i += 2) s += {16'h0, got[i], got[i+1]};
                while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
                check("ip checksum folds to FFFF", s[15:0], 16'hFFFF);
            end
`endif
            ip_id_model = ip_id_model + 16'd1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " hdr_valid"}, hdr_valid, 0);
        check({tag, " hdr_data"},  hdr_data, 0);
        check({tag, " hdr_keep"},  hdr_keep, 0);
        check({tag, " hdr_last"},  hdr_last, 0);
        check({tag, " err_pulse"}, err_pulse, 0);
        check({tag, " busy"},      busy, 0);
        check({tag, " ram_addr"},  ram_addr, 0);
    endtask

    vec_t tv [0:5];
    rec_t r;

    initial begin
        for (int i = 0; i < (1<<(ID_W+4)); i++) mem[i] = 32'h0;
        r = '{1'b1, 48'h001122334455, 48'h66778899AABB, 32'hC0A80001, 32'hC0A80002,
              16'h1F90, 16'h0050, 32'd1000, 32'd2000};
        load_rec(3, r);
        r.valid = 1'b0; r.mac_dst = 48'hDEADBEEF0005;
        load_rec(5, r);
        r = '{1'b1, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 32'h0A000001, 32'h0A0000FE,
              16'hC350, 16'h01BB, 32'hFFFFFFF0, 32'h12345678};
        load_rec(7, r);

        tv[0] = '{5, 8'h12, 16'd0,     1'b0, 1'b1, 0,      16'h0000};
        tv[1] = '{3, 8'h12, 16'd0,     1'b0, 1'b0, NBEATS, 16'h0028};
        tv[2] = '{3, 8'h12, 16'd0,     1'b1, 1'b0, NBEATS, 16'h0028};
        tv[3] = '{3, 8'h10, 16'd65496, 1'b0, 1'b1, 0,      16'h0000};
        tv[4] = '{3, 8'h10, 16'd65495, 1'b0, 1'b0, NBEATS, 16'hFFFF};
        tv[5] = '{7, 8'h18, 16'd1460,  1'b1, 1'b0, NBEATS, 16'h05DC};

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_txn(tv[i].id, tv[i].flags, tv[i].len, tv[i].rnd, tv[i].exp_err, tv[i].exp_beats, tv[i].exp_total);

        // Reset asserted while beat 5 is on the bus.
        begin
            int seen, cyc;
            bit hit;
            seen = 0; cyc = 0; hit = 0;
            req_valid = 1'b1; req_id = 6'd3; req_flags = 8'h12; req_len = 16'd0; hdr_ready = 1'b1;
            while (!hit && cyc < 200) begin
                @(posedge clk); #1; cyc++;
                req_valid = 1'b0;
                if (hdr_valid) begin
                    if (seen == 5) hit = 1;
                    else seen++;
                end
            end
            check("reached beat 5 before reset", hit, 1);
            rst = 1'b0; hdr_ready = 1'b0;
            @(posedge clk); #1;
            check_idle_outputs("mid-stream reset");
            rst = 1'b1;
            ip_id_model = 16'h0000;
            @(posedge clk); #1;
            run_txn(3, 8'h12, 16'd0, 1'b0, 1'b0, NBEATS, 16'h0028);
        end

        for (int k = 0; k < 8; k++) begin
            logic [15:0] len;
            logic [7:0]  fl;
            bit          e;
            r.valid   = ($urandom_range(0, 3) != 0);
            r.mac_dst = {16'($urandom), 32'($urandom)};
            r.mac_src = {16'($urandom), 32'($urandom)};
            r.ip_src  = $urandom; r.ip_dst = $urandom;
            r.sport   = 16'($urandom); r.dport = 16'($urandom);
            r.seq     = $urandom; r.ack = $urandom;
            load_rec(10 + k, r);
            len = ($urandom_range(0, 4) == 0) ? 16'(65490 + $urandom_range(0, 45)) : 16'($urandom_range(0, 9000));
            fl  = 8'($urandom);
            e   = !r.valid || (len > 16'd65495);
            run_txn(10 + k, fl, len, 1'b1, e, e ? 0 : NBEATS, 16'd40 + len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
